// File: rtl/risc_isa_pkg.sv
// ISA constants for the 16-bit RISC core: opcodes, one-hot ALU controls and instruction field positions.
// Shared by the fetch/decode stage, the D->E control pipeline and the ALU.
package risc_isa_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_LW   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    localparam logic [7:0] ALU_NONE = 8'h00;
    localparam logic [7:0] ALU_ADD  = 8'h01;
    localparam logic [7:0] ALU_SUB  = 8'h02;
    localparam logic [7:0] ALU_AND  = 8'h04;
    localparam logic [7:0] ALU_OR   = 8'h08;
    localparam logic [7:0] ALU_XOR  = 8'h10;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int RD_MSB     = 11;
    localparam int RD_LSB     = 9;
    localparam int RS1_MSB    = 8;
    localparam int RS1_LSB    = 6;
    localparam int RS2_MSB    = 5;
    localparam int RS2_LSB    = 3;
    localparam int IMM_MSB    = 5;
    localparam int IMM_LSB    = 0;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    function automatic logic [15:0] sign_extend_imm(input logic [15:0] instr);
        return {{10{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB]};
    endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Purely combinational decode of the IF/ID instruction word into the D-stage control bundle.
// An invalid D slot (bubble) never writes state and is never reported as illegal.
module instruction_decoder
    import risc_isa_pkg::*;
(
    input  logic [15:0] instr_d,
    input  logic        valid_d,
    output logic        illegal_d,
    output logic        reg_write_d,
    output logic [2:0]  reg_write_adr_d,
    output logic        mem_to_reg_d,
    output logic        mem_write_d,
    output logic [7:0]  ALU_con_d,
    output logic        ALU_source2_d,
    output logic [15:0] offset_register_d,
    output logic [2:0]  reg_read_adr1_d,
    output logic [2:0]  reg_read_adr2_d
);

    logic [3:0] opcode;
    logic       reg_write_raw;
    logic       mem_to_reg_raw;
    logic       mem_write_raw;
    logic       illegal_raw;

    assign opcode = instr_d[OPCODE_MSB:OPCODE_LSB];

    // Register fields are extracted unconditionally; only SW moves the second read port to [11:9].
    always_comb begin
        reg_write_raw     = 1'b0;
        mem_to_reg_raw    = 1'b0;
        mem_write_raw     = 1'b0;
        illegal_raw       = 1'b0;
        ALU_con_d         = ALU_NONE;
        ALU_source2_d     = 1'b0;
        reg_write_adr_d   = instr_d[RD_MSB:RD_LSB];
        reg_read_adr1_d   = instr_d[RS1_MSB:RS1_LSB];
        reg_read_adr2_d   = instr_d[RS2_MSB:RS2_LSB];
        offset_register_d = sign_extend_imm(instr_d);

        case (opcode)
            OP_NOP: ;
            OP_ADD: begin reg_write_raw = 1'b1; ALU_con_d = ALU_ADD; end
            OP_SUB: begin reg_write_raw = 1'b1; ALU_con_d = ALU_SUB; end
            OP_AND: begin reg_write_raw = 1'b1; ALU_con_d = ALU_AND; end
            OP_OR:  begin reg_write_raw = 1'b1; ALU_con_d = ALU_OR;  end
            OP_XOR: begin reg_write_raw = 1'b1; ALU_con_d = ALU_XOR; end
            OP_ADDI: begin
                reg_write_raw = 1'b1;
                ALU_con_d     = ALU_ADD;
                ALU_source2_d = 1'b1;
            end
            OP_LW: begin
                reg_write_raw  = 1'b1;
                mem_to_reg_raw = 1'b1;
                ALU_con_d      = ALU_ADD;
                ALU_source2_d  = 1'b1;
            end
            OP_SW: begin
                mem_write_raw   = 1'b1;
                ALU_con_d       = ALU_ADD;
                ALU_source2_d   = 1'b1;
                reg_read_adr2_d = instr_d[RD_MSB:RD_LSB];
            end
            default: illegal_raw = 1'b1;
        endcase
    end

    assign reg_write_d  = valid_d & reg_write_raw;
    assign mem_to_reg_d = valid_d & mem_to_reg_raw;
    assign mem_write_d  = valid_d & mem_write_raw;
    assign illegal_d    = valid_d & illegal_raw;

endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch + IF/ID stage: PC register, IF/ID register and decode into the *_d control bundle.
// Optional macro STALL_COUNTER_EN adds a saturating stall_cycles counter port.
module fetch_decode_stage
    import risc_isa_pkg::*;
#(
    parameter int                    PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
`ifdef STALL_COUNTER_EN
    output logic [15:0]         stall_cycles,
`endif
    output logic [PC_WIDTH-1:0] instr_mem_adr,
    input  logic [15:0]         instr_mem_data,
    input  logic                stall_f,
    input  logic                stall_d,
    input  logic                flush_d,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] pc_d,
    output logic                valid_d,
    output logic                illegal_d,
    output logic                reg_write_d,
    output logic [2:0]          reg_write_adr_d,
    output logic                mem_to_reg_d,
    output logic                mem_write_d,
    output logic [7:0]          ALU_con_d,
    output logic                ALU_source2_d,
    output logic [15:0]         offset_register_d,
    output logic [2:0]          reg_read_adr1_d,
    output logic [2:0]          reg_read_adr2_d
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    logic [PC_WIDTH-1:0] pc_f;
    logic [15:0]         instr_d;

    assign instr_mem_adr = pc_f;

    // A redirect beats stall_f: the resolver's target must not be lost while fetch is frozen.
    always_ff @(posedge clock) begin
        if (reset)
            pc_f <= RESET_PC;
        else if (branch_taken)
            pc_f <= branch_target;
        else if (!stall_f)
            pc_f <= pc_f + PC_ONE;
    end

    always_ff @(posedge clock) begin
        if (reset || flush_d) begin
            instr_d <= NOP_INSTR;
            pc_d    <= '0;
            valid_d <= 1'b0;
        end else if (!stall_d) begin
            instr_d <= instr_mem_data;
            pc_d    <= pc_f;
            valid_d <= 1'b1;
        end
    end

`ifdef STALL_COUNTER_EN
    // Counts only genuine D holds; a flush overrides the stall, so that cycle is not counted.
    always_ff @(posedge clock) begin
        if (reset)
            stall_cycles <= 16'h0000;
        else if (stall_d && !flush_d && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'h0001;
    end
`endif

    instruction_decoder u_decoder (
        .instr_d           (instr_d),
        .valid_d           (valid_d),
        .illegal_d         (illegal_d),
        .reg_write_d       (reg_write_d),
        .reg_write_adr_d   (reg_write_adr_d),
        .mem_to_reg_d      (mem_to_reg_d),
        .mem_write_d       (mem_write_d),
        .ALU_con_d         (ALU_con_d),
        .ALU_source2_d     (ALU_source2_d),
        .offset_register_d (offset_register_d),
        .reg_read_adr1_d   (reg_read_adr1_d),
        .reg_read_adr2_d   (reg_read_adr2_d)
    );

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: directed scenarios plus random stall/flush/branch traffic against a cycle model.
// Define STALL_COUNTER_EN to also exercise the stall_cycles port.
module tb_fetch_decode_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] instr_mem_adr;
    logic [15:0] instr_mem_data;
    logic        stall_f, stall_d, flush_d, branch_taken;
    logic [15:0] branch_target;
    logic [15:0] pc_d;
    logic        valid_d, illegal_d, reg_write_d, mem_to_reg_d, mem_write_d, ALU_source2_d;
    logic [2:0]  reg_write_adr_d, reg_read_adr1_d, reg_read_adr2_d;
    logic [7:0]  ALU_con_d;
    logic [15:0] offset_register_d;
`ifdef STALL_COUNTER_EN
    logic [15:0] stall_cycles;
`endif

    logic [15:0] mem [256];
    int total = 0;
    int bad = 0;

    // Reference state: what the stage should hold after each clock edge.
    logic [15:0] m_pc, m_pcd, m_instr, m_stalls;
    logic        m_valid;

    always #5 clock = ~clock;

    assign instr_mem_data = mem[instr_mem_adr[7:0]];

    fetch_decode_stage dut (
        .clock             (clock),
        .reset             (reset),
`ifdef STALL_COUNTER_EN
        .stall_cycles      (stall_cycles),
`endif
        .instr_mem_adr     (instr_mem_adr),
        .instr_mem_data    (instr_mem_data),
        .stall_f           (stall_f),
        .stall_d           (stall_d),
        .flush_d           (flush_d),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .pc_d              (pc_d),
        .valid_d           (valid_d),
        .illegal_d         (illegal_d),
        .reg_write_d       (reg_write_d),
        .reg_write_adr_d   (reg_write_adr_d),
        .mem_to_reg_d      (mem_to_reg_d),
        .mem_write_d       (mem_write_d),
        .ALU_con_d         (ALU_con_d),
        .ALU_source2_d     (ALU_source2_d),
        .offset_register_d (offset_register_d),
        .reg_read_adr1_d   (reg_read_adr1_d),
        .reg_read_adr2_d   (reg_read_adr2_d)
    );

    logic [38:0] dut_bundle;
    assign dut_bundle = {valid_d, illegal_d, reg_write_d, reg_write_adr_d, mem_to_reg_d, mem_write_d,
                         ALU_con_d, ALU_source2_d, offset_register_d, reg_read_adr1_d, reg_read_adr2_d};

    // Expected decode from the ISA table: R-types map opcode n to ALU bit n-1, memory ops use ADD + offset.
    function automatic logic [38:0] model_decode(input logic [15:0] ins, input logic v);
        logic [3:0]  op;
        logic        is_r, is_mem, wr, mtr, mw, ill;
        logic [7:0]  alu;
        logic [2:0]  rd2;
        op     = ins[15:12];
        is_r   = (op >= 4'd1) && (op <= 4'd5);
        is_mem = (op >= 4'd6) && (op <= 4'd8);
        alu    = is_r ? (8'h01 << (op - 4'd1)) : (is_mem ? 8'h01 : 8'h00);
        wr     = v && (is_r || op == 4'd6 || op == 4'd7);
        mtr    = v && (op == 4'd7);
        mw     = v && (op == 4'd8);
        ill    = v && (op >= 4'd9);
        rd2    = (op == 4'd8) ? ins[11:9] : ins[5:3];
        return {v, ill, wr, ins[11:9], mtr, mw, alu, is_mem, {{10{ins[5]}}, ins[5:0]}, ins[8:6], rd2};
    endfunction

    task automatic applyStimulus(input logic rst, input logic sf, input logic sd, input logic fd,
                                 input logic bt, input logic [15:0] tgt);
        logic [15:0] old_pc;
        reset = rst; stall_f = sf; stall_d = sd; flush_d = fd; branch_taken = bt; branch_target = tgt;
        @(posedge clock);
        old_pc = m_pc;
        if (rst) begin
            m_pc = 16'h0000; m_pcd = 16'h0000; m_instr = 16'h0000; m_valid = 1'b0; m_stalls = 16'h0000;
        end else begin
            m_pc = bt ? tgt : (sf ? m_pc : m_pc + 16'd1);
            if (fd) begin
                m_pcd = 16'h0000; m_instr = 16'h0000; m_valid = 1'b0;
            end else if (!sd) begin
                m_pcd = old_pc; m_instr = mem[old_pc[7:0]]; m_valid = 1'b1;
            end
            if (sd && !fd && m_stalls != 16'hFFFF) m_stalls = m_stalls + 16'd1;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [38:0] zero_bundle;
        zero_bundle = '0;
        applyStimulus(1, 0, 0, 0, 0, 16'h0);
        applyStimulus(1, 0, 0, 0, 0, 16'h0);
        total++;
        if (instr_mem_adr !== 16'h0000 || pc_d !== 16'h0000 || dut_bundle !== zero_bundle) begin
            bad++;
            $display("[TB] FAIL reset_state: adr=%h pc_d=%h bundle=%h want 0000 0000 %h",
                     instr_mem_adr, pc_d, dut_bundle, zero_bundle);
        end
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 16'h0);
            total++;
            if (instr_mem_adr !== 16'(i) || valid_d !== 1'b1) begin
                bad++;
                $display("[TB] FAIL reset_fetch_seq: adr=%h valid=%b want %h 1", instr_mem_adr, valid_d, 16'(i));
            end
        end
    endtask

    task automatic test_decode();
        mem[0] = 16'h1298;
        mem[1] = 16'h86BF;
        applyStimulus(1, 0, 0, 0, 0, 16'h0);
        applyStimulus(0, 0, 0, 0, 0, 16'h0);
        total++;
        if ({reg_write_d, reg_write_adr_d, reg_read_adr1_d, reg_read_adr2_d, ALU_con_d, ALU_source2_d} !==
            {1'b1, 3'd1, 3'd2, 3'd3, 8'h01, 1'b0}) begin
            bad++;
            $display("[TB] FAIL decode_add: rw=%b adr=%0d rd1=%0d rd2=%0d alu=%h src2=%b want 1 1 2 3 01 0",
                     reg_write_d, reg_write_adr_d, reg_read_adr1_d, reg_read_adr2_d, ALU_con_d, ALU_source2_d);
        end
        applyStimulus(0, 0, 0, 0, 0, 16'h0);
        total++;
        if ({mem_write_d, reg_write_d, reg_read_adr1_d, reg_read_adr2_d, offset_register_d, ALU_source2_d} !==
            {1'b1, 1'b0, 3'd2, 3'd3, 16'hFFFF, 1'b1}) begin
            bad++;
            $display("[TB] FAIL decode_sw: mw=%b rw=%b rd1=%0d rd2=%0d off=%h src2=%b want 1 0 2 3 ffff 1",
                     mem_write_d, reg_write_d, reg_read_adr1_d, reg_read_adr2_d, offset_register_d, ALU_source2_d);
        end
    endtask

    task automatic test_stall();
        logic [38:0] held;
        applyStimulus(1, 0, 0, 0, 0, 16'h0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 16'h0);
        held = dut_bundle;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 1, 1, 0, 0, 16'h0);
            total++;
            if (instr_mem_adr !== 16'd5 || pc_d !== 16'd4 || dut_bundle !== held) begin
                bad++;
                $display("[TB] FAIL stall_hold: adr=%h pc_d=%h bundle=%h want 0005 0004 %h",
                         instr_mem_adr, pc_d, dut_bundle, held);
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 16'h0);
        total++;
        if (instr_mem_adr !== 16'd6 || pc_d !== 16'd5) begin
            bad++;
            $display("[TB] FAIL stall_release: adr=%h pc_d=%h want 0006 0005", instr_mem_adr, pc_d);
        end
    endtask

    task automatic test_branch_wrap();
        mem[8'h40] = 16'h1298;
        applyStimulus(0, 1, 0, 1, 1, 16'h0040);
        total++;
        if (instr_mem_adr !== 16'h0040 || valid_d !== 1'b0 || reg_write_d !== 1'b0) begin
            bad++;
            $display("[TB] FAIL branch_flush: adr=%h valid=%b rw=%b want 0040 0 0", instr_mem_adr, valid_d, reg_write_d);
        end
        applyStimulus(0, 0, 0, 0, 1, 16'hFFFF);
        applyStimulus(0, 0, 0, 0, 0, 16'h0);
        total++;
        if (instr_mem_adr !== 16'h0000 || pc_d !== 16'hFFFF || valid_d !== 1'b1) begin
            bad++;
            $display("[TB] FAIL pc_wrap: adr=%h pc_d=%h valid=%b want 0000 ffff 1", instr_mem_adr, pc_d, valid_d);
        end
        applyStimulus(0, 0, 1, 1, 0, 16'h0);
        total++;
        if (valid_d !== 1'b0 || pc_d !== 16'h0000 || reg_write_d !== 1'b0) begin
            bad++;
            $display("[TB] FAIL flush_over_stall: valid=%b pc_d=%h rw=%b want 0 0000 0", valid_d, pc_d, reg_write_d);
        end
        applyStimulus(1, 1, 1, 0, 0, 16'h0);
        total++;
        if (instr_mem_adr !== 16'h0000 || valid_d !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid_stall: adr=%h valid=%b want 0000 0", instr_mem_adr, valid_d);
        end
    endtask

`ifdef STALL_COUNTER_EN
    task automatic test_stall_counter();
        applyStimulus(1, 0, 0, 0, 0, 16'h0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 0, 16'h0);
        applyStimulus(0, 0, 1, 1, 0, 16'h0);
        total++;
        if (stall_cycles !== 16'd3) begin
            bad++;
            $display("[TB] FAIL stall_counter: got %0d want 3", stall_cycles);
        end
    endtask
`endif

    task automatic test_random();
        logic rst, sf, sd, fd, bt;
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            sf  = ($urandom_range(0, 3) == 0);
            sd  = ($urandom_range(0, 3) == 0);
            fd  = ($urandom_range(0, 6) == 0);
            bt  = ($urandom_range(0, 9) == 0);
            applyStimulus(rst, sf, sd, fd, bt, 16'($urandom));
            total++;
            if (instr_mem_adr !== m_pc || pc_d !== m_pcd) begin
                bad++;
                $display("[TB] FAIL rand_pc: adr=%h pc_d=%h want %h %h", instr_mem_adr, pc_d, m_pc, m_pcd);
            end
            total++;
            if (dut_bundle !== model_decode(m_instr, m_valid)) begin
                bad++;
                $display("[TB] FAIL rand_decode: bundle=%h want %h (instr %h)",
                         dut_bundle, model_decode(m_instr, m_valid), m_instr);
            end
`ifdef STALL_COUNTER_EN
            total++;
            if (stall_cycles !== m_stalls) begin
                bad++;
                $display("[TB] FAIL rand_stall_count: got %0d want %0d", stall_cycles, m_stalls);
            end
`endif
        end
    endtask

    initial begin
        reset = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
        branch_taken = 1'b0; branch_target = 16'h0;
        m_pc = 16'h0; m_pcd = 16'h0; m_instr = 16'h0; m_valid = 1'b0; m_stalls = 16'h0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        #1;
        test_reset();
        test_decode();
        test_stall();
        test_branch_wrap();
`ifdef STALL_COUNTER_EN
        test_stall_counter();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
